// File: rtl/osc_pkg.sv
// Shared types for the two-case oscillator arbiter.
// Arbiter encoding, core state names, requester indices.
package osc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD   = 2'd1,
    ARB_SWITCH = 2'd2
  } arb_e;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  localparam int CASE1 = 0;
  localparam int CASE2 = 1;

endpackage

// File: rtl/osc_pair_core.sv
// Two-case oscillator: phase toggles, or case flips on a.
// y mirrors the switch command as a Mealy output.
module osc_pair_core
  import osc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  output logic [1:0] state,
  output logic       y
);

  logic [1:0] state_q, state_d;

  // next core state: flip case on a, else toggle phase
  always_comb begin
    state_d = state_q;
    if (a) state_d = {~state_q[1], state_q[0]};
    else   state_d = {state_q[1], ~state_q[0]};
  end

  // core state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S00;
    else      state_q <= state_d;
  end

  assign state = state_q;
  assign y     = a;

endmodule

// File: rtl/osc_case_arbiter.sv
// Grants the shared oscillator to one of two requesters,
// switching case on handover with a minimum dwell slot.
module osc_case_arbiter
  import osc_pkg::*;
#(
  parameter int SLOT_CYCLES = 8,
  parameter int CNT_W       = $clog2(SLOT_CYCLES),
  parameter int SWC_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  output logic [1:0]       osc_state,
  output logic             a_out,
  output logic             busy,
  output logic [SWC_W-1:0] sw_count
);

  localparam logic [CNT_W-1:0] DWELL_MAX =
    CNT_W'(SLOT_CYCLES - 1);

  arb_e             arb_q, arb_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [SWC_W-1:0] swc_q, swc_d;
  logic             sw_cmd;
  logic             owner;
  logic             req_own, req_oth;

  osc_pair_core u_core (
    .clk   (clk),
    .rst   (rst),
    .a     (sw_cmd),
    .state (osc_state),
    .y     (a_out)
  );

  assign owner   = osc_state[1];
  assign req_own = owner ? req[CASE2] : req[CASE1];
  assign req_oth = owner ? req[CASE1] : req[CASE2];

  // next arbiter state, counters and switch command
  always_comb begin
    arb_d   = arb_q;
    dwell_d = dwell_q;
    swc_d   = swc_q;
    sw_cmd  = 1'b0;
    grant   = 2'b00;
    unique case (arb_q)
      ARB_IDLE: begin
        if (req_own) begin
          arb_d   = ARB_HOLD;
          dwell_d = '0;
        end else if (req_oth) begin
          arb_d = ARB_SWITCH;
        end
      end
      ARB_HOLD: begin
        grant = owner ? 2'b10 : 2'b01;
        if (dwell_q != DWELL_MAX)
          dwell_d = dwell_q + 1'b1;
        if (!req_own && req_oth)
          arb_d = ARB_SWITCH;
        else if (!req_own)
          arb_d = ARB_IDLE;
        else if (req_oth && dwell_q == DWELL_MAX)
          arb_d = ARB_SWITCH;
      end
      ARB_SWITCH: begin
        sw_cmd = 1'b1;
        swc_d  = swc_q + 1'b1;
        // the core flips case on this edge: old other owns next
        if (req_oth) begin
          arb_d   = ARB_HOLD;
          dwell_d = '0;
        end else if (req_own) begin
          arb_d = ARB_SWITCH;
        end else begin
          arb_d = ARB_IDLE;
        end
      end
      default: arb_d = ARB_IDLE;
    endcase
  end

  // arbiter state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_q   <= ARB_IDLE;
      dwell_q <= '0;
      swc_q   <= '0;
    end else begin
      arb_q   <= arb_d;
      dwell_q <= dwell_d;
      swc_q   <= swc_d;
    end
  end

  assign busy     = (arb_q != ARB_IDLE);
  assign sw_count = swc_q;

endmodule

// File: tb/tb_osc_case_arbiter.sv
// Directed bench for osc_case_arbiter.
// Scenario tasks with hand-computed expectations.
module tb_osc_case_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] osc_state;
  logic       a_out;
  logic       busy;
  logic [7:0] sw_count;

  int errors = 0;
  int checks = 0;

  osc_case_arbiter #(
    .SLOT_CYCLES (8),
    .SWC_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .osc_state (osc_state),
    .a_out     (a_out),
    .busy      (busy),
    .sw_count  (sw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    req = 2'b00;
    rst = 1'b0;
    #12;
    @(negedge clk);
    checks++;
    if ({osc_state, grant, a_out, busy, sw_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_init: got osc=%b gnt=%b a=%b busy=%b sw=%0d, want 0",
               osc_state, grant, a_out, busy, sw_count);
    end
    rst = 1'b1;
    req = 2'b01;
    step();
    step();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL reset_prehold: grant=%b want 01", grant);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({osc_state, grant, a_out, busy, sw_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_midhold: got osc=%b gnt=%b a=%b busy=%b sw=%0d, want 0",
               osc_state, grant, a_out, busy, sw_count);
    end
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (osc_state !== ((i % 2 == 0) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL reset_run[%0d]: osc=%b want %b", i, osc_state,
                 (i % 2 == 0) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_owner();
    do_reset();
    req = 2'b01;
    step();
    checks++;
    if ({grant, osc_state, a_out, busy} !== {2'b01, 2'b01, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL owner_grant: gnt=%b osc=%b a=%b busy=%b want 01 01 0 1",
               grant, osc_state, a_out, busy);
    end
    step();
    checks++;
    if ({grant, osc_state, a_out, sw_count} !== {2'b01, 2'b00, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL owner_hold: gnt=%b osc=%b a=%b sw=%0d want 01 00 0 0",
               grant, osc_state, a_out, sw_count);
    end
  endtask

  task automatic test_cross();
    do_reset();
    req = 2'b10;
    step();
    checks++;
    if ({grant, a_out, busy, osc_state} !== {2'b00, 1'b1, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL cross_switch: gnt=%b a=%b busy=%b osc=%b want 00 1 1 01",
               grant, a_out, busy, osc_state);
    end
    step();
    checks++;
    if ({grant, a_out, osc_state, sw_count} !== {2'b10, 1'b0, 2'b11, 8'd1}) begin
      errors++;
      $display("FAIL cross_hold: gnt=%b a=%b osc=%b sw=%0d want 10 0 11 1",
               grant, a_out, osc_state, sw_count);
    end
    step();
    checks++;
    if ({grant, osc_state} !== {2'b10, 2'b10}) begin
      errors++;
      $display("FAIL cross_phase: gnt=%b osc=%b want 10 10", grant, osc_state);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({osc_state, grant, sw_count} !== 12'd0) begin
      errors++;
      $display("FAIL cross_reset: osc=%b gnt=%b sw=%0d want 00 00 0",
               osc_state, grant, sw_count);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_preempt();
    logic [1:0] exp;
    do_reset();
    req = 2'b11;
    for (int k = 1; k <= 36; k++) begin
      step();
      if ((k - 1) % 9 == 8) exp = 2'b00;
      else if (((k - 1) / 9) % 2 == 0) exp = 2'b01;
      else exp = 2'b10;
      checks++;
      if (grant !== exp || a_out !== (exp == 2'b00)) begin
        errors++;
        $display("FAIL preempt[%0d]: gnt=%b a=%b want gnt %b", k, grant,
                 a_out, exp);
      end
    end
    step();
    checks++;
    if (sw_count !== 8'd4 || grant !== 2'b01) begin
      errors++;
      $display("FAIL preempt_count: sw=%0d gnt=%b want 4 01", sw_count, grant);
    end
  endtask

  task automatic test_release();
    do_reset();
    req = 2'b01;
    step();
    step();
    req = 2'b00;
    step();
    checks++;
    if ({busy, grant, osc_state} !== {1'b0, 2'b00, 2'b01}) begin
      errors++;
      $display("FAIL release_idle: busy=%b gnt=%b osc=%b want 0 00 01",
               busy, grant, osc_state);
    end
    step();
    checks++;
    if ({busy, osc_state} !== {1'b0, 2'b00}) begin
      errors++;
      $display("FAIL release_phase: busy=%b osc=%b want 0 00", busy, osc_state);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_sw;
    do_reset();
    req = 2'b10;
    step();
    for (int i = 0; i < 256; i++) begin
      req = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      exp_sw = 8'((i + 1) % 256);
      checks++;
      if (sw_count !== exp_sw || grant !== 2'b00 || a_out !== 1'b1) begin
        errors++;
        $display("FAIL wrap[%0d]: sw=%0d gnt=%b a=%b want sw %0d gnt 00 a 1",
                 i, sw_count, grant, a_out, exp_sw);
      end
    end
    req = 2'b00;
    step();
    checks++;
    if ({busy, a_out, sw_count} !== {1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL wrap_end: busy=%b a=%b sw=%0d want 0 0 1",
               busy, a_out, sw_count);
    end
  endtask

  initial begin
    req = 2'b00;
    rst = 1'b0;
    test_reset();
    test_owner();
    test_cross();
    test_preempt();
    test_release();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osc_case_arbiter.md
Name: osc_case_arbiter

Overview:
Arbitration controller that shares the two-case oscillator between two requesters. Requester 0 owns case 1 (states 00-01) and requester 1 owns case 2 (states 10-11). The block embeds the oscillator core and drives its switch input A so that the oscillator runs in the case of the current grant holder. It enforces a minimum dwell slot before preempting the holder, and counts case switches for debug.

Parameters:
SLOT_CYCLES, 8, minimum number of HOLD cycles before the holder can be preempted by the other requester; legal range is at least 2.
CNT_W, $clog2(SLOT_CYCLES), width of the dwell counter.
SWC_W, 8, width of the wrapping switch counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low.
req  in  2  req[i]=1 means requester i wants the oscillator; level-sensitive.
grant  out  2  one-hot grant (or 00); combinational from registered state.
osc_state  out  2  oscillator state; bit1 is the case, bit0 is the phase.
a_out  out  1  switch command to the core, also the Mealy y output; 1 only in SWITCH.
busy  out  1  1 whenever the arbiter is not in IDLE.
sw_count  out  SWC_W  number of completed case switches; wraps.

Behaviour:
- Reset (rst=0, asynchronous):
  - arb=IDLE, osc_state=00, dwell_cnt=0, sw_count=0.
  - Therefore grant=00, a_out=0, busy=0.
  - Reset mid-operation aborts any slot or switch immediately; there is no pending state.
- Oscillator core, updated every clk edge:
  - a_out=0: bit0 toggles, bit1 holds (00->01->00, 10->11->10).
  - a_out=1: bit1 flips, bit0 holds (00<->10, 01<->11).
- Owner: owner = osc_state[1]; other = ~owner.
- Arbiter states: IDLE, HOLD, SWITCH.
- Outputs by state:
  - grant[owner]=1 only in HOLD; otherwise grant=00.
  - a_out=1 only in SWITCH.
- IDLE:
  - req[owner]=1 -> HOLD, dwell_cnt<=0. If both requests are high, the owner wins because it costs no switch.
  - else if req[other]=1 -> SWITCH.
  - else stay in IDLE.
- HOLD:
  - dwell_cnt increments each cycle and saturates at SLOT_CYCLES-1.
  - req[owner]=0 and req[other]=1 -> SWITCH.
  - req[owner]=0 and req[other]=0 -> IDLE.
  - req[owner]=1, req[other]=1 and dwell_cnt==SLOT_CYCLES-1 -> SWITCH (preemption).
  - otherwise stay in HOLD.
- SWITCH (exactly one cycle):
  - a_out=1, so the core flips case on this edge.
  - sw_count <= sw_count+1, with wrap.
  - Next state is evaluated against the NEW owner, i.e. the old other:
    - req[new owner]=1 -> HOLD, dwell_cnt<=0.
    - else if req[old owner]=1 -> SWITCH (switch back).
    - else IDLE.
- Latency:
  - Request to the current-case owner while IDLE: grant one cycle later.
  - Request to the other case while IDLE: grant two cycles later (SWITCH, then HOLD).
  - Worst-case wait for a contender: SLOT_CYCLES+1 cycles after the holder enters HOLD.
- Invariants:
  - grant is never 11.
  - grant is never asserted while a_out=1.
  - A grant always matches osc_state[1].
  - The phase bit toggles every cycle except during SWITCH cycles.
- Starvation: with both requests held high, the holder alternates every SLOT_CYCLES+1 cycles.
- dwell_cnt width: CNT_W bits; it holds at saturation and never wraps.

Decomposition:
- Shared package osc_pkg:
  - arb state encoding ARB_IDLE=2'd0, ARB_HOLD=2'd1, ARB_SWITCH=2'd2.
  - core state constants S00..S11.
  - index constants CASE1=0, CASE2=1.
- One sub-module, osc_pair_core: the 2-bit oscillator register with input a and outputs state and y. It uses the same clk/rst convention and is instantiated once.
- Arbiter FSM, dwell counter and switch counter live in the top module.

Test Plan:
- Reset: assert rst=0 mid-HOLD with req=01 -> next sample shows osc_state=00, grant=00, a_out=0, sw_count=0; after release, osc_state runs 00,01,00...
- Owner request: req=01 from IDLE -> grant=01 one cycle later; osc_state toggles 00/01; a_out stays 0; sw_count stays 0.
- Cross request: req=10 from IDLE with case 1 -> one cycle with a_out=1 and grant=00, then grant=10; osc_state bit1=1; sw_count=1.
- Preemption: SLOT_CYCLES=8, req=11 held -> grant alternates 01 (8 cycles), 00 (1 cycle), 10 (8 cycles), and so on; sw_count=4 after four switches.
- Release: holder drops its request with the other idle -> IDLE next cycle; busy=0; osc_state keeps toggling the phase in the same case.
- Wrap: force 256 switches with SWC_W=8 -> sw_count returns to 0; grant stays one-hot or 00 throughout.
